cycle_sequencer: RTL and testbench
==================================

# cycle_sequencer

Parametrised instruction-cycle sequencer for the 4004-style core: the generalised replacement for the fixed 8-phase counter. It generates the phase index, a one-hot phase decode and the SYNC pulse from `toggle_clk`. It adds a post-reset startup hold, run/halt control at instruction boundaries, single-step, and an instruction-cycle counter. It sits between the clock toggle logic and the core's phase-decoded datapath/bus logic.

## Interface
- `PHASES`, 8: phases per instruction cycle. Legal range is 2 to 2^CW.
- `CW`, 3: width of `cycle`.
- `SYNC_PHASE`, 7: phase at which `sync` is asserted. Must be less than PHASES.
- `STARTUP`, 64: clocks held after reset release before sequencing. Must be at least 1.
- `COUNT_W`, 16: width of `instr_count`.
- `toggle_clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  1 = free-run; 0 = halt at the next instruction boundary.
- `step`  in  1  while halted with `run`=0, executes exactly one instruction cycle.
- `cycle`  out  CW  current phase, 0..PHASES-1.
- `phase_onehot`  out  PHASES  bit `cycle` set while active; all-zero otherwise.
- `sync`  out  1  high for the one clock where active and `cycle`==SYNC_PHASE.
- `ready`  out  1  high once startup hold has completed.
- `halted`  out  1  high in HALT state.
- `instr_count`  out  COUNT_W  completed instruction cycles, modulo 2^COUNT_W.

## Operation
- States: STARTUP, RUN, HALT, STEP. "Active" means RUN or STEP.
- Reset (async, immediate, no clock needed): state=STARTUP, cycle=0, startup counter=0, instr_count=0. Outputs: ready=0, halted=0, sync=0, phase_onehot=0.
- STARTUP
  - cycle is held at 0 and the startup counter increments each clock.
  - On the clock where the counter equals STARTUP-1: go to RUN if `run`=1, else go to HALT.
- RUN
  - cycle increments each clock.
  - At cycle==PHASES-1 the next value is 0 (wrap) and instr_count increments.
  - `run` is sampled only on the wrap clock. If it is 0, the next state is HALT.
- HALT
  - cycle is held at 0; halted=1; sync=0; phase_onehot=0.
  - `run`=1 moves to RUN. Otherwise `step`=1 moves to STEP.
  - `run` has priority over `step`.
- STEP
  - Counts exactly as RUN.
  - On the wrap clock: next state is RUN if `run`=1, else HALT.
  - `step` is ignored while in STEP and in RUN.
- `cycle` is registered. `phase_onehot`, `sync`, `ready` and `halted` are decoded from registered state/cycle only; they have no combinational path from `run` or `step`.
- instr_count wraps from 2^COUNT_W-1 to 0 silently.
- Values of `cycle` at or above PHASES are unreachable.

## Timing
- Release rst, then exactly STARTUP rising edges until `ready`=1.
  - With `run`=1, the first active clock shows cycle=0.
  - The next edge shows cycle=1.
- Instruction cycle length is exactly PHASES clocks. The sync period is PHASES clocks.
- Dropping `run` mid-cycle does not shorten the current cycle.
  - Sequencing completes through PHASES-1.
  - The edge after that enters HALT with cycle=0.
- Leaving HALT:
  - If `run`/`step` is high at edge k, the state is active after edge k with cycle=0.
  - cycle=1 after edge k+1.
  - HALT contributes at least one inactive clock at phase 0.
- A single-step pulse (one clock, sampled in HALT) produces exactly PHASES active clocks, one sync pulse and instr_count+1, then returns to HALT.
- `rst` asserted at any point overrides all state within the same clock period (asynchronous). Deassertion is synchronous to the system.

## Test plan
- Startup: STARTUP=4, rst high 3 clocks, run=1 → ready=0 for 4 edges after release; then cycle 0,1,…,7,0; sync high only at cycle=7; phase_onehot=8'h01,8'h02,…,8'h80.
- Free run: 3 full instruction cycles after ready → instr_count=3; sync pulses exactly 8 clocks apart; halted stays 0.
- Halt at boundary: drop run while cycle=3 → cycle continues 4..7; sync fires once; then halted=1, cycle=0, phase_onehot=0, sync=0 held for 20 clocks.
- Single step: from HALT, step high 1 clock → exactly 8 active clocks, one sync, instr_count+1, back to halted=1. A second step pulse during STEP has no effect. step together with run=1 enters RUN.
- Async reset mid-run: assert rst between edges while cycle=5 → cycle=0, instr_count=0, ready=0, sync=0 before the next edge; STARTUP sequence restarts on release.
- Parameter variant: PHASES=5, SYNC_PHASE=2, CW=3, COUNT_W=2 → cycle 0..4 wraps; sync at cycle 2; instr_count wraps 3→0 after the 4th cycle.

Source files
------------

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: instruction-cycle phase generator for the 4004-style core.
// Produces the phase index, a one-hot phase decode and SYNC, with a
// post-reset startup hold, run/halt at instruction boundaries, single-step
// and a completed-instruction counter.
module cycle_sequencer #(
  parameter int PHASES     = 8,
  parameter int CW         = 3,
  parameter int SYNC_PHASE = 7,
  parameter int STARTUP    = 64,
  parameter int COUNT_W    = 16
) (
  input  logic               toggle_clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  output logic [CW-1:0]      cycle,
  output logic [PHASES-1:0]  phase_onehot,
  output logic               sync,
  output logic               ready,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  // The startup counter only has to reach STARTUP-1.
  localparam int SCW = (STARTUP > 1) ? $clog2(STARTUP) : 1;

  localparam logic [CW-1:0]      CYC_LAST  = CW'(PHASES - 1);
  localparam logic [CW-1:0]      CYC_SYNC  = CW'(SYNC_PHASE);
  localparam logic [CW-1:0]      CYC_ONE   = CW'(1);
  localparam logic [SCW-1:0]     SCNT_LAST = SCW'(STARTUP - 1);
  localparam logic [SCW-1:0]     SCNT_ONE  = SCW'(1);
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2,
    ST_STEP    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cycle_q, cycle_d;
  logic [SCW-1:0]     scnt_q, scnt_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               active_s;

  // State, phase, startup counter and instruction counter registers.
  always_ff @(posedge toggle_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STARTUP;
      cycle_q <= '0;
      scnt_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      scnt_q  <= scnt_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: RUN and STEP sequence identically; run is only looked
  // at on the wrap clock so an instruction cycle is never cut short.
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    scnt_d  = scnt_q;
    count_d = count_q;
    case (state_q)
      ST_STARTUP: begin
        cycle_d = '0;
        if (scnt_q == SCNT_LAST) begin
          state_d = run ? ST_RUN : ST_HALT;
        end else begin
          scnt_d = scnt_q + SCNT_ONE;
        end
      end
      ST_RUN, ST_STEP: begin
        if (cycle_q == CYC_LAST) begin
          cycle_d = '0;
          count_d = count_q + CNT_ONE;
          state_d = run ? ST_RUN : ST_HALT;
        end else begin
          cycle_d = cycle_q + CYC_ONE;
        end
      end
      ST_HALT: begin
        cycle_d = '0;
        if (run) begin
          state_d = ST_RUN;
        end else if (step) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_STARTUP;
        cycle_d = '0;
        scnt_d  = '0;
      end
    endcase
  end

  // Output decode from registered state and phase only (no path from run/step).
  always_comb begin
    active_s     = (state_q == ST_RUN) || (state_q == ST_STEP);
    phase_onehot = '0;
    for (int i = 0; i < PHASES; i++) begin
      phase_onehot[i] = active_s && (cycle_q == CW'(i));
    end
    sync   = active_s && (cycle_q == CYC_SYNC);
    ready  = (state_q != ST_STARTUP);
    halted = (state_q == ST_HALT);
  end

  assign cycle       = cycle_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: two instances (8-phase and a
// 5-phase / 2-bit-counter variant) driven by the same randomized run/step/rst
// stimulus and compared every clock against an abstract reference model.
module tb_cycle_sequencer;

  localparam int PH  [2] = '{8, 5};
  localparam int SP  [2] = '{7, 2};
  localparam int SU  [2] = '{4, 3};
  localparam int MOD [2] = '{65536, 4};

  logic toggle_clk = 1'b0;
  logic rst, run, step;

  logic [2:0]  a_cycle;
  logic [7:0]  a_onehot;
  logic        a_sync, a_ready, a_halted;
  logic [15:0] a_count;

  logic [2:0]  b_cycle;
  logic [4:0]  b_onehot;
  logic        b_sync, b_ready, b_halted;
  logic [1:0]  b_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining startup clocks, whether an instruction is in
  // progress and at which position, halt flag, completed instructions.
  int m_wait [2];
  bit m_act  [2];
  bit m_halt [2];
  int m_pos  [2];
  int m_cnt  [2];

  always #5 toggle_clk = ~toggle_clk;

  cycle_sequencer #(.PHASES(8), .CW(3), .SYNC_PHASE(7), .STARTUP(4), .COUNT_W(16)) dut_a (
    .toggle_clk(toggle_clk), .rst(rst), .run(run), .step(step),
    .cycle(a_cycle), .phase_onehot(a_onehot), .sync(a_sync),
    .ready(a_ready), .halted(a_halted), .instr_count(a_count)
  );

  cycle_sequencer #(.PHASES(5), .CW(3), .SYNC_PHASE(2), .STARTUP(3), .COUNT_W(2)) dut_b (
    .toggle_clk(toggle_clk), .rst(rst), .run(run), .step(step),
    .cycle(b_cycle), .phase_onehot(b_onehot), .sync(b_sync),
    .ready(b_ready), .halted(b_halted), .instr_count(b_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = SU[i];
      m_act[i]  = 1'b0;
      m_halt[i] = 1'b0;
      m_pos[i]  = 0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_edge(input bit r, input bit s);
    for (int i = 0; i < 2; i++) begin
      if (m_wait[i] > 0) begin
        m_wait[i]--;
        if (m_wait[i] == 0) begin
          if (r) begin m_act[i] = 1'b1; m_pos[i] = 0; end
          else   m_halt[i] = 1'b1;
        end
      end else if (m_act[i]) begin
        if (m_pos[i] == PH[i] - 1) begin
          m_pos[i] = 0;
          m_cnt[i] = (m_cnt[i] + 1) % MOD[i];
          if (!r) begin m_act[i] = 1'b0; m_halt[i] = 1'b1; end
        end else begin
          m_pos[i]++;
        end
      end else if (r || s) begin
        m_act[i]  = 1'b1;
        m_halt[i] = 1'b0;
        m_pos[i]  = 0;
      end
    end
  endtask

  task automatic check_dut(input int i, input logic [31:0] cyc, input logic [31:0] oh,
                           input logic [31:0] sy, input logic [31:0] rd,
                           input logic [31:0] hl, input logic [31:0] cnt);
    int e_cyc;
    int e_oh;
    e_cyc = m_act[i] ? m_pos[i] : 0;
    e_oh  = m_act[i] ? (1 << m_pos[i]) : 0;
    check($sformatf("d%0d.cycle", i), cyc, 32'(e_cyc));
    check($sformatf("d%0d.onehot", i), oh, 32'(e_oh));
    check($sformatf("d%0d.sync", i), sy, 32'(m_act[i] && (m_pos[i] == SP[i])));
    check($sformatf("d%0d.ready", i), rd, 32'(m_wait[i] == 0));
    check($sformatf("d%0d.halted", i), hl, 32'(m_halt[i]));
    check($sformatf("d%0d.count", i), cnt, 32'(m_cnt[i]));
  endtask

  task automatic check_all();
    check_dut(0, 32'(a_cycle), 32'(a_onehot), 32'(a_sync), 32'(a_ready), 32'(a_halted), 32'(a_count));
    check_dut(1, 32'(b_cycle), 32'(b_onehot), 32'(b_sync), 32'(b_ready), 32'(b_halted), 32'(b_count));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare 1 time unit after the edge.
  task automatic tick();
    @(posedge toggle_clk);
    if (rst) model_reset();
    else     model_edge(run, step);
    #1;
    check_all();
  endtask

  // Advance until instance A sits at the given phase, bounded.
  task automatic wait_pos_a(input int p);
    int budget;
    budget = 40;
    while (!(m_act[0] && m_pos[0] == p) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("wait_pos_timeout", 32'(m_pos[0]), 32'(p));
  endtask

  // Assert reset between edges and verify outputs clear before any edge.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    run  = 1'b1;
    step = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (3) tick();
    rst = 1'b0;

    // Startup hold followed by three full free-running instructions.
    repeat (SU[0] + 3 * PH[0]) tick();
    check("free_run_count", 32'(a_count), 32'd3);

    // Drop run mid-instruction; halt lands on the boundary, then hold.
    wait_pos_a(3);
    run = 1'b0;
    repeat (25) tick();

    // Single step, with a second step pulse inside STEP.
    step = 1'b1; tick();
    step = 1'b0; repeat (3) tick();
    step = 1'b1; tick();
    step = 1'b0; repeat (12) tick();

    // step together with run enters free run.
    step = 1'b1; run = 1'b1; tick();
    step = 1'b0; repeat (12) tick();

    // Asynchronous reset mid-run, then restart.
    wait_pos_a(5);
    async_reset();
    repeat (SU[0] + 10) tick();

    // Randomized run/step/reset traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      step = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 799) == 0) async_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
